// File: rtl/power_sched_if.sv
// Request/response bundle for the shared exponentiation engine: two requesters,
// one result port and a busy indicator.
interface power_sched_if #(
  parameter int unsigned IN_W  = 10,
  parameter int unsigned OUT_W = 12
);
  logic             req0_valid;
  logic [IN_W-1:0]  req0_base;
  logic [IN_W-1:0]  req0_exp;
  logic             req0_ready;
  logic             req1_valid;
  logic [IN_W-1:0]  req1_base;
  logic [IN_W-1:0]  req1_exp;
  logic             req1_ready;
  logic             rsp_valid;
  logic             rsp_id;
  logic [OUT_W-1:0] rsp_result;
  logic             rsp_ovf;
  logic             rsp_ready;
  logic             busy;

  modport master (
    output req0_valid, req0_base, req0_exp, req1_valid, req1_base, req1_exp, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_ovf, busy
  );

  modport slave (
    input  req0_valid, req0_base, req0_exp, req1_valid, req1_base, req1_exp, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_ovf, busy
  );
endinterface

// File: rtl/power_sched.sv
// Square-and-multiply base^exp mod 2^OUT_W, one exponent bit per clock, shared
// by two requesters through a round-robin front end. Flags true overflow.
module power_sched #(
  parameter int unsigned IN_W  = 10,
  parameter int unsigned OUT_W = 12
) (
  input  logic         clk,
  input  logic         rst,
  power_sched_if.slave bus
);
  localparam int unsigned PW = 2 * OUT_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] r_b;
  logic [IN_W-1:0]  r_e;
  logic             r_ovf;
  logic             r_bovf;
  logic             r_id;
  logic             r_ptr;
  logic             r_rsp_valid;
  logic             r_busy;

  logic             w_gnt0;
  logic             w_gnt1;
  logic [IN_W-1:0]  w_base;
  logic [IN_W-1:0]  w_exp;
  logic [PW-1:0]    w_mul;
  logic [PW-1:0]    w_sq;
  logic [IN_W-1:0]  w_e_nx;

  // A lone valid requester wins regardless of the pointer.
  assign w_gnt0 = !rst && (r_state == IDLE) && bus.req0_valid && (!bus.req1_valid || !r_ptr);
  assign w_gnt1 = !rst && (r_state == IDLE) && bus.req1_valid && (!bus.req0_valid || r_ptr);
  assign w_base = w_gnt1 ? bus.req1_base : bus.req0_base;
  assign w_exp  = w_gnt1 ? bus.req1_exp  : bus.req0_exp;
  assign w_mul  = PW'(r_acc) * PW'(r_b);
  assign w_sq   = PW'(r_b) * PW'(r_b);
  assign w_e_nx = r_e >> 1;

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_id;
  assign bus.rsp_result = r_acc;
  assign bus.rsp_ovf    = r_ovf;
  assign bus.busy       = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_b         <= '0;
      r_e         <= '0;
      r_ovf       <= 1'b0;
      r_bovf      <= 1'b0;
      r_id        <= 1'b0;
      r_ptr       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_b     <= OUT_W'(w_base);
            r_e     <= w_exp;
            r_acc   <= OUT_W'(1);
            r_ovf   <= 1'b0;
            r_bovf  <= 1'b0;
            r_id    <= w_gnt1;
            r_ptr   <= ~w_gnt1;
            r_busy  <= 1'b1;
            r_state <= (w_exp != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          // A base that already overflowed poisons every product it enters.
          if (r_e[0]) begin
            r_acc <= w_mul[OUT_W-1:0];
            if ((|w_mul[PW-1:OUT_W]) || r_bovf) r_ovf <= 1'b1;
          end
          r_b <= w_sq[OUT_W-1:0];
          if (|w_sq[PW-1:OUT_W]) r_bovf <= 1'b1;
          r_e <= w_e_nx;
          if (w_e_nx == '0) r_state <= DONE;
        end
        DONE: begin
          // First DONE cycle raises rsp_valid; the handshake returns to IDLE.
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
          end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_power_sched.sv
// Scoreboarded bench for power_sched: grants, results, overflow, latency,
// backpressure and asynchronous reset.
module tb_power_sched;
  localparam int unsigned IN_W  = 10;
  localparam int unsigned OUT_W = 12;

  typedef struct {
    logic             id;
    logic [OUT_W-1:0] res;
    logic             ovf;
    int               acc_cyc;
    int               k;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  power_sched_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
  power_sched #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  logic mptr   = 1'b0;
  logic prev_v = 1'b0;
  logic g0, g1;
  exp_t x, y;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  // Reference: repeated multiplication with a saturating true value.
  function automatic exp_t model(input logic id, input logic [IN_W-1:0] b, input logic [IN_W-1:0] e);
    exp_t   m;
    longint t = 1;
    logic [OUT_W-1:0] r = OUT_W'(1);
    logic   o = 1'b0;
    int     k = 0;
    for (int i = 0; i < int'(e); i++) begin
      r = OUT_W'(PW_MUL(r, b));
      if (!o) begin
        t = t * longint'(b);
        if (t >= 4096) o = 1'b1;
      end
    end
    for (int i = 0; i < int'(IN_W); i++) if (e[i]) k = i + 1;
    m.id = id; m.res = r; m.ovf = o; m.acc_cyc = 0; m.k = k;
    return m;
  endfunction

  function automatic logic [2*OUT_W-1:0] PW_MUL(input logic [OUT_W-1:0] a, input logic [IN_W-1:0] b);
    return (2*OUT_W)'(a) * (2*OUT_W)'(b);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: push at grant, compare latency at rsp_valid rise, pop at handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (bus.req0_ready || bus.req1_ready) begin
        g0 = bus.req0_valid && (!bus.req1_valid || !mptr);
        g1 = bus.req1_valid && (!bus.req0_valid || mptr);
        check("grant", 32'({bus.req1_ready, bus.req0_ready}), 32'({g1, g0}));
        mptr = ~g1;
        x = model(g1, g1 ? bus.req1_base : bus.req0_base, g1 ? bus.req1_exp : bus.req0_exp);
        x.acc_cyc = cyc + 1;
        sb.push_back(x);
      end
      if (bus.rsp_valid && !prev_v) begin
        if (sb.size() > 0) check("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].k + 1));
        else check("spurious_valid", 32'(bus.rsp_valid), 32'd0);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() > 0) begin
          y = sb.pop_front();
          check("rsp_id", 32'(bus.rsp_id), 32'(y.id));
          check("rsp_result", 32'(bus.rsp_result), 32'(y.res));
          check("rsp_ovf", 32'(bus.rsp_ovf), 32'(y.ovf));
        end else begin
          check("spurious_rsp", 32'(bus.rsp_valid), 32'd0);
        end
      end
      prev_v = bus.rsp_valid;
    end
  end

  task automatic issue(input int id, input int b, input int e);
    bit got = 0;
    @(posedge clk); #1;
    if (id == 0) begin
      bus.req0_valid = 1'b1; bus.req0_base = IN_W'(b); bus.req0_exp = IN_W'(e);
    end else begin
      bus.req1_valid = 1'b1; bus.req1_base = IN_W'(b); bus.req1_exp = IN_W'(e);
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((id == 0) ? bus.req0_ready : bus.req1_ready) begin got = 1; break; end
    end
    if (!got) check("ready_timeout", 32'((id == 0) ? bus.req0_ready : bus.req1_ready), 32'd1);
    @(posedge clk); #1;
    if (id == 0) bus.req0_valid = 1'b0;
    else bus.req1_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !bus.busy) begin ok = 1; break; end
    end
    if (!ok) check("drain", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
    check({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
    check({tag, "_rsp_ovf"}, 32'(bus.rsp_ovf), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_ready"}, 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    bit ok;
    bus.req0_valid = 1'b1; bus.req0_base = '0; bus.req0_exp = '0;
    bus.req1_valid = 1'b0; bus.req1_base = '0; bus.req1_exp = '0;
    bus.rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #2 check_zero_outputs("reset");
    bus.req0_valid = 1'b0;
    @(posedge clk); #3 rst = 1'b0;

    // Arbitration: both requesters contend; grants must alternate 0,1,0,1.
    fork
      begin issue(0, 3, 5);  issue(0, 2, 9); end
      begin issue(1, 5, 4);  issue(1, 7, 3); end
    join
    drain();

    // Directed values, one at a time.
    issue(0, 3, 5);    drain();
    issue(1, 2, 12);   drain();
    issue(0, 64, 2);   drain();
    issue(1, 5, 5);    drain();
    issue(0, 3, 8);    drain();
    issue(0, 0, 0);    drain();
    issue(1, 0, 7);    drain();
    issue(0, 1, 1023); drain();
    issue(1, 1023, 1); drain();
    for (int i = 0; i < 6; i++) begin
      issue(int'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 20)));
      drain();
    end

    // Backpressure with a competing request held pending.
    bus.rsp_ready = 1'b0;
    issue(0, 5, 5);
    fork
      issue(1, 7, 3);
      begin
        ok = 0;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (bus.rsp_valid) begin ok = 1; break; end
        end
        check("bp_valid_seen", 32'(ok), 32'd1);
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          check("bp_valid", 32'(bus.rsp_valid), 32'd1);
          check("bp_result", 32'(bus.rsp_result), 32'd3125);
          check("bp_busy", 32'(bus.busy), 32'd1);
          check("bp_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        end
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset in the middle of a long run.
    issue(0, 1, 1023);
    repeat (4) @(posedge clk);
    #2 check("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1 check_zero_outputs("async_reset");
    sb.delete();
    mptr = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (15) @(posedge clk);
    #2 check("post_reset_idle", 32'({bus.rsp_valid, bus.busy}), 32'd0);
    issue(1, 7, 2); drain();
    issue(0, 2, 11); drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/power_sched.md
# power_sched

Multi-cycle exponentiation engine with a two-port round-robin front end for the calculator datapath. It computes base^exp modulo 2^OUT_W, plus an overflow flag, using square-and-multiply at one exponent bit per clock. It lets two requesters share a single power resource, for example the keypad operation path and the expression evaluator. It replaces the unrolled combinational power loop, whose logic depth grew with the exponent.

## Interface
Parameters:
- IN_W, 10, width of base and exponent
- OUT_W, 12, width of result; arithmetic is modulo 2^OUT_W

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has an operation pending
- req0_base  in  IN_W  requester 0 base
- req0_exp  in  IN_W  requester 0 exponent
- req0_ready  out  1  requester 0 operation accepted this cycle
- req1_valid / req1_base / req1_exp / req1_ready  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_id  out  1  index of the requester that owns the result
- rsp_result  out  OUT_W  base^exp mod 2^OUT_W
- rsp_ovf  out  1  true base^exp >= 2^OUT_W
- rsp_ready  in  1  consumer takes the result
- busy  out  1  state is not IDLE

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- **IDLE**
  - Grant one valid requester; reqN_ready is combinational and high only for the granted requester.
  - On the accept edge, latch the following: b_reg = base zero-extended to OUT_W, e_reg = exp, acc = 1, ovf = 0, b_ovf = 0, id = N.
  - Next state is RUN if exp != 0, otherwise DONE.
- **Arbitration**
  - Round-robin with a 1-bit pointer to the preferred requester. The pointer resets to 0.
  - After each grant, the pointer moves to the other requester.
  - With a single requester valid, that requester is granted regardless of the pointer.
- **RUN** (one cycle per step)
  - If e_reg[0]: acc <= (acc*b_reg)[OUT_W-1:0]. Set ovf if the full 2*OUT_W product has any upper bit set, or if b_ovf is set.
  - Always: b_reg <= (b_reg*b_reg)[OUT_W-1:0]. Set b_ovf (sticky) if the full square's upper bits are nonzero.
  - Always: e_reg <= e_reg >> 1.
  - Exit to DONE when the shifted e_reg == 0.
  - ovf is sticky.
  - b_ovf only affects ovf through a later multiply. A square that overflows after the final used bit does not set ovf.
- **DONE**
  - rsp_valid = 1; rsp_id, rsp_result (= acc) and rsp_ovf are stable.
  - On rsp_valid && rsp_ready, go to IDLE.
  - No request is accepted while in RUN or DONE; both reqN_ready are 0.
- **Requester rule:** reqN_valid, base and exp must stay stable until reqN_ready. Dropping valid before ready withdraws the request without effect.
- **Special values**
  - exp = 0 gives result 1, ovf 0, including 0^0.
  - base = 0 with exp != 0 gives 0, ovf 0.
  - base = 1 gives 1, ovf 0.

## Timing
- Reset values: rsp_valid 0, rsp_id 0, rsp_result 0, rsp_ovf 0, busy 0, req0_ready 0, req1_ready 0 while rst is high. Internal acc, b_reg, e_reg, ovf, b_ovf and the pointer are all 0.
- Let k = index of the highest set bit of exp plus 1 (0 for exp = 0; maximum IN_W = 10).
- Accept at edge T. RUN occupies cycles T+1 to T+k. rsp_valid rises at edge T+k+1, so latency is k+1 cycles (1 cycle for exp = 0).
- rsp_valid holds indefinitely under backpressure.
- After the response handshake edge, the FSM is in IDLE for at least one cycle. The earliest next accept is at the following edge.
- Minimum occupancy is k+3 cycles per operation with rsp_ready tied high.
- busy is high from the cycle after accept through the cycle of the response handshake.
- Reset asserted mid-RUN or in DONE: the operation is discarded immediately (asynchronously), no response is produced, and the pointer returns to 0.

## Test plan
- **Basic:** req0 base=3, exp=5, rsp_ready=1 -> rsp_result=243, rsp_ovf=0, rsp_id=0, rsp_valid exactly 4 cycles after accept (k=3).
- **Overflow:** req1 base=2, exp=12 -> result 0, ovf 1, id 1. base=64, exp=2 -> result 0, ovf 1. base=5, exp=5 -> 3125, ovf 0. base=3, exp=8 -> 6561 mod 4096 = 2465, ovf 1.
- **Edge values:** 0^0 -> 1, ovf 0, latency 1. 0^7 -> 0, ovf 0. 1^1023 -> 1, ovf 0, latency 11. 1023^1 -> 1023, ovf 0.
- **Arbitration:** both requesters held valid continuously from reset -> grants alternate 0,1,0,1. Each reqN_ready pulses exactly once per grant, and the rsp_id sequence matches the grants.
- **Backpressure:** rsp_ready held 0 for 20 cycles in DONE -> rsp_valid and the data stay stable, busy=1, no reqN_ready. Releasing rsp_ready gives one handshake, then IDLE.
- **Reset mid-op:** assert rst during RUN of 1^1023 -> all outputs 0 within the same cycle, no response after release. A new request completes normally.
